// File: rtl/gpio_irq.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// gpio_irq : GPIO peripheral with debounced, edge-triggered interrupts
//
// Drives GpoWidth outputs through atomic set/clear/toggle writes. Samples
// GpiWidth asynchronous inputs through a three-flop synchroniser and an
// optional debouncer. Rising/falling edges of the debounced inputs are
// latched as sticky, write-one-to-clear interrupt bits.
//
// Compile-time option:
//   GPIO_IRQ_DBNC_EN  when defined, the debounce prescaler and the per-pin
//                     counters are built and DBNC_CNT is a live register.
//                     When undefined, the debounced value is simply the
//                     synchronised input and DBNC_CNT reads as 0.
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   device_req_i     bus request (one-cycle, no back-pressure)
//   device_addr_i    byte address, bits [11:2] select the word register
//   device_we_i      write enable
//   device_be_i      byte enables, gate every write per byte
//   device_wdata_i   write data
//   device_rvalid_o  response valid, one cycle after every request
//   device_rdata_o   registered read data, 0 for writes/unmapped addresses
//   gp_i             raw asynchronous inputs
//   gp_o             registered outputs
//   irq_o            level interrupt: |(INTR_STATE & (EN_RISE | EN_FALL))
//
// Register map (byte offsets):
//   0x00 OUT  RW | 0x04 IN  RO | 0x08 IN_DBNC RO | 0x0C OUT_SET WO
//   0x10 OUT_CLR WO | 0x14 OUT_TGL WO | 0x18 INTR_EN_RISE RW
//   0x1C INTR_EN_FALL RW | 0x20 INTR_STATE RW1C | 0x24 DBNC_CNT RW
//
// Parameter limits: GpiWidth, GpoWidth and DbncCntWidth must be 1..32.
// ---------------------------------------------------------------------------
module gpio_irq #(
  parameter int unsigned GpiWidth     = 8,
  parameter int unsigned GpoWidth     = 16,
  parameter int unsigned DbncCntWidth = 16,
  parameter int unsigned DbncResetCnt = 500
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                device_req_i,
  input  logic [31:0]         device_addr_i,
  input  logic                device_we_i,
  input  logic [3:0]          device_be_i,
  input  logic [31:0]         device_wdata_i,
  output logic                device_rvalid_o,
  output logic [31:0]         device_rdata_o,
  input  logic [GpiWidth-1:0] gp_i,
  output logic [GpoWidth-1:0] gp_o,
  output logic                irq_o
);

  // Word indices (byte offset >> 2)
  localparam logic [9:0] RegOut     = 10'd0;
  localparam logic [9:0] RegIn      = 10'd1;
  localparam logic [9:0] RegInDbnc  = 10'd2;
  localparam logic [9:0] RegOutSet  = 10'd3;
  localparam logic [9:0] RegOutClr  = 10'd4;
  localparam logic [9:0] RegOutTgl  = 10'd5;
  localparam logic [9:0] RegEnRise  = 10'd6;
  localparam logic [9:0] RegEnFall  = 10'd7;
  localparam logic [9:0] RegState   = 10'd8;
  localparam logic [9:0] RegDbncCnt = 10'd9;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic [9:0]  reg_idx;
  logic        wr;
  logic        rd;
  logic [31:0] be_mask;
  logic [31:0] wdata_m;

  assign reg_idx = device_addr_i[11:2];
  assign wr      = device_req_i & device_we_i;
  assign rd      = device_req_i & ~device_we_i;
  assign be_mask = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                    {8{device_be_i[1]}}, {8{device_be_i[0]}}};
  // Byte-gated write data; used directly by set/clear/toggle/W1C so that a
  // disabled byte lane can never modify anything.
  assign wdata_m = device_wdata_i & be_mask;

  // -------------------------------------------------------------------------
  // Output register with atomic set/clear/toggle aliases
  // -------------------------------------------------------------------------
  logic [GpoWidth-1:0] out_q;
  logic [GpoWidth-1:0] out_next;

  always_comb begin
    out_next = out_q;
    if (wr) begin
      case (reg_idx)
        RegOut:    out_next = (out_q & ~be_mask[GpoWidth-1:0]) | wdata_m[GpoWidth-1:0];
        RegOutSet: out_next = out_q | wdata_m[GpoWidth-1:0];
        RegOutClr: out_next = out_q & ~wdata_m[GpoWidth-1:0];
        RegOutTgl: out_next = out_q ^ wdata_m[GpoWidth-1:0];
        default:   out_next = out_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else begin
      out_q <= out_next;
    end
  end

  assign gp_o = out_q;

  // -------------------------------------------------------------------------
  // Interrupt enable registers
  // -------------------------------------------------------------------------
  logic [GpiWidth-1:0] en_rise_q;
  logic [GpiWidth-1:0] en_fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_rise_q <= '0;
      en_fall_q <= '0;
    end else begin
      if (wr && (reg_idx == RegEnRise)) begin
        en_rise_q <= (en_rise_q & ~be_mask[GpiWidth-1:0]) | wdata_m[GpiWidth-1:0];
      end
      if (wr && (reg_idx == RegEnFall)) begin
        en_fall_q <= (en_fall_q & ~be_mask[GpiWidth-1:0]) | wdata_m[GpiWidth-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Three-flop input synchroniser; the third stage is the IN register
  // -------------------------------------------------------------------------
  logic [GpiWidth-1:0] sync1_q;
  logic [GpiWidth-1:0] sync2_q;
  logic [GpiWidth-1:0] sync3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= gp_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // -------------------------------------------------------------------------
  // Debouncer
  // -------------------------------------------------------------------------
  logic [GpiWidth-1:0] dbnc;
  logic [31:0]         dbnc_cnt_rd;

`ifdef GPIO_IRQ_DBNC_EN
  logic [DbncCntWidth-1:0]  dbnc_cnt_q;
  logic [DbncCntWidth-1:0]  presc_q;
  logic                     dbnc_cnt_wr;
  logic                     tick;
  logic [GpiWidth-1:0][1:0] pin_cnt_q;
  logic [GpiWidth-1:0][1:0] pin_cnt_next;
  logic [GpiWidth-1:0]      dbnc_q;
  logic [GpiWidth-1:0]      dbnc_next;

  assign dbnc_cnt_wr = wr && (reg_idx == RegDbncCnt);
  assign tick        = (presc_q == dbnc_cnt_q);

  // Prescaler period register; any write restarts the prescaler so the tick
  // phase is well defined relative to the write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbnc_cnt_q <= DbncCntWidth'(DbncResetCnt);
    end else if (dbnc_cnt_wr) begin
      dbnc_cnt_q <= (dbnc_cnt_q & ~be_mask[DbncCntWidth-1:0]) | wdata_m[DbncCntWidth-1:0];
    end
  end

  // Free-running prescaler: wraps to 0 on the tick cycle, so the tick period
  // is DBNC_CNT + 1 cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else if (dbnc_cnt_wr || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + DbncCntWidth'(1);
    end
  end

  // Per-pin stability counter: a differing sample on three consecutive ticks
  // commits the new level; any agreeing sample restarts the count.
  always_comb begin
    pin_cnt_next = pin_cnt_q;
    dbnc_next    = dbnc_q;
    if (tick) begin
      for (int i = 0; i < GpiWidth; i++) begin
        if (sync3_q[i] != dbnc_q[i]) begin
          if (pin_cnt_q[i] == 2'd2) begin
            dbnc_next[i]    = sync3_q[i];
            pin_cnt_next[i] = 2'd0;
          end else begin
            pin_cnt_next[i] = pin_cnt_q[i] + 2'd1;
          end
        end else begin
          pin_cnt_next[i] = 2'd0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pin_cnt_q <= '0;
      dbnc_q    <= '0;
    end else begin
      pin_cnt_q <= pin_cnt_next;
      dbnc_q    <= dbnc_next;
    end
  end

  assign dbnc        = dbnc_q;
  assign dbnc_cnt_rd = 32'(dbnc_cnt_q);
`else
  // No debouncing: edges are taken straight from the synchroniser output and
  // the period register does not exist.
  logic [DbncCntWidth-1:0] unused_dbnc_rst;

  assign unused_dbnc_rst = DbncCntWidth'(DbncResetCnt);
  assign dbnc            = sync3_q;
  assign dbnc_cnt_rd     = '0;
`endif

  // -------------------------------------------------------------------------
  // Edge detection and sticky interrupt state
  // -------------------------------------------------------------------------
  logic [GpiWidth-1:0] dbnc_prev_q;
  logic [GpiWidth-1:0] edge_set;
  logic [GpiWidth-1:0] state_clr;
  logic [GpiWidth-1:0] state_q;

  assign edge_set  = ( dbnc & ~dbnc_prev_q & en_rise_q)
                   | (~dbnc &  dbnc_prev_q & en_fall_q);
  assign state_clr = (wr && (reg_idx == RegState)) ? wdata_m[GpiWidth-1:0] : '0;

  // Clear is applied before set, so a new edge wins over a simultaneous W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbnc_prev_q <= '0;
      state_q     <= '0;
    end else begin
      dbnc_prev_q <= dbnc;
      state_q     <= (state_q & ~state_clr) | edge_set;
    end
  end

  assign irq_o = |(state_q & (en_rise_q | en_fall_q));

  // -------------------------------------------------------------------------
  // Read mux and response registers
  // -------------------------------------------------------------------------
  logic [31:0] rdata_next;
  logic [31:0] rdata_q;
  logic        rvalid_q;

  always_comb begin
    rdata_next = '0;
    if (rd) begin
      case (reg_idx)
        RegOut:     rdata_next = 32'(out_q);
        RegIn:      rdata_next = 32'(sync3_q);
        RegInDbnc:  rdata_next = 32'(dbnc);
        RegEnRise:  rdata_next = 32'(en_rise_q);
        RegEnFall:  rdata_next = 32'(en_fall_q);
        RegState:   rdata_next = 32'(state_q);
        RegDbncCnt: rdata_next = dbnc_cnt_rd;
        default:    rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= device_req_i;
      rdata_q  <= rdata_next;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;

  // Address bits outside the decoded window and write-data bits beyond the
  // register widths are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{device_addr_i[31:12], device_addr_i[1:0], wdata_m, be_mask};

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
- Parametrised successor GPIO peripheral on the Ibex demo system device bus.
- Drives GpoWidth outputs with atomic set/clear/toggle writes.
- Samples GpiWidth inputs through a 3-flop synchroniser and a runtime-programmable debouncer.
- Flags rising/falling edges of debounced inputs as maskable, sticky interrupts (W1C) combined onto irq_o.

Parameters:
- GpiWidth, 8, number of inputs (1..32).
- GpoWidth, 16, number of outputs (1..32).
- DbncCntWidth, 16, width of debounce prescaler and DBNC_CNT register.
- DbncResetCnt, 500, reset value of DBNC_CNT.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- device_req_i  in  1  bus request
- device_addr_i  in  32  byte address; only [11:0] decoded
- device_we_i  in  1  write enable
- device_be_i  in  4  byte enables
- device_wdata_i  in  32  write data
- device_rvalid_o  out  1  response valid
- device_rdata_o  out  32  read data
- gp_i  in  GpiWidth  raw asynchronous inputs
- gp_o  out  GpoWidth  registered outputs
- irq_o  out  1  level interrupt, |(INTR_STATE & (EN_RISE|EN_FALL))

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: every flop is 0 except DBNC_CNT = DbncResetCnt. Outputs gp_o, device_rvalid_o, device_rdata_o and irq_o are all 0.
- Bus timing: device_rvalid_o is asserted exactly 1 cycle after every device_req_i, read or write. device_rdata_o is registered, valid with rvalid, and 0 for writes and unmapped addresses. No back-pressure; back-to-back requests are allowed.
- Register map (offsets):
  - 0x00 OUT: RW, byte-enabled.
  - 0x04 IN: RO, synchronised input.
  - 0x08 IN_DBNC: RO, debounced input.
  - 0x0C OUT_SET: WO, gp_o |= wdata.
  - 0x10 OUT_CLR: WO, gp_o &= ~wdata.
  - 0x14 OUT_TGL: WO, gp_o ^= wdata.
  - 0x18 INTR_EN_RISE: RW.
  - 0x1C INTR_EN_FALL: RW.
  - 0x20 INTR_STATE: RW1C.
  - 0x24 DBNC_CNT: RW.
- Register width rules: WO registers read 0. Byte enables gate every write per byte. Bits at or above the relevant width are ignored on write and read as 0.
- Output update: gp_o changes on the clock edge that accepts the write.
- Synchroniser: gp_i passes through 3 flops. IN shows the 3rd stage.
- Debounce prescaler: a free-running counter emits a 1-cycle tick when it equals DBNC_CNT, then wraps to 0.
  - DBNC_CNT = 0 gives a tick every cycle.
  - Writing DBNC_CNT resets the prescaler to 0.
- Debounce per pin: a 2-bit counter.
  - On each tick, if sync != dbnc the counter increments; otherwise it clears.
  - When the counter would reach 3, dbnc takes the sync value and the counter clears.
  - Net effect: a change must be stable for 3 consecutive ticks before it propagates.
- Edge detect: compares dbnc with dbnc delayed by 1 cycle.
  - A rising edge on pin i sets INTR_STATE[i] when INTR_EN_RISE[i] = 1.
  - A falling edge on pin i sets INTR_STATE[i] when INTR_EN_FALL[i] = 1.
  - Enables do not clear state already latched.
- Set/clear collision: an edge set and a W1C clear of the same bit in the same cycle leave the bit set (set wins).
- irq_o timing: combinational from registered state, so it asserts 1 cycle after the edge-detect cycle.
- Mid-operation reset: an assertion mid-operation clears all state immediately, including in-flight rvalid and debounce progress.

Optional Feature:
- Macro: GPIO_IRQ_DBNC_EN.
- Defined: debounce prescaler and per-pin counters are present as described above.
- Undefined:
  - No debounce logic is instantiated; dbnc equals the synchronised input.
  - IN_DBNC reads the same value as IN, and edges are detected on the synchronised input.
  - DBNC_CNT reads 0 and ignores writes.

Test Plan:
- Reset, then read 0x24 and 0x00 -> rdata 500 and 0; rvalid one cycle after each req; irq_o = 0.
- Write OUT = 0x00FF with be = 4'b0001, then OUT_SET = 0x0F00, then OUT_CLR = 0x0003, then OUT_TGL = 0x8001 -> gp_o reads 0x00FF, 0x0FFF, 0x0FFC, 0x8FFD.
- With DBNC_CNT = 3, drive gp_i[0] 0 to 1 and hold -> IN[0] = 1 after 3 cycles; IN_DBNC[0] = 1 after 12–16 cycles (3 ticks at 4-cycle period).
  - Glitch gp_i[0] high for 6 cycles instead -> IN_DBNC never changes.
- With INTR_EN_RISE = 0x01 and INTR_EN_FALL = 0x02:
  - Debounced rise on pin 0 -> INTR_STATE = 0x01 and irq_o = 1.
  - Write INTR_STATE = 0x01 -> irq_o = 0.
  - Debounced rise on pin 1 -> no interrupt; its fall -> INTR_STATE = 0x02.
- Time the W1C write of INTR_STATE bit 0 to land on the same cycle as a new pin-0 rising edge -> bit remains 1 and irq_o stays high.
- Read 0x40 (unmapped) and write 0x04 (RO) -> rdata 0; no state change; rvalid still asserted.
